// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; queued words go out back-to-back.
// Optional parity bit is compiled in by defining UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Overflow
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int BIT_W     = $clog2(DATA_BITS);
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CLK_W     = $clog2(STOP_CLKS);

  localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] STOP_LAST = CLK_W'(STOP_CLKS - 1);
  localparam logic [CLK_W-1:0] STOP_PRE  = CLK_W'(STOP_CLKS - 2);
  localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t                 state;
  logic [CLK_W-1:0]       clk_cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shift;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic push;
  logic pop;
  logic frame_end;

  assign o_Tx_Ready   = (count < CNT_W'(FIFO_DEPTH));
  assign o_Fifo_Count = count;
  assign push         = i_Tx_DV & o_Tx_Ready;
  assign frame_end    = (state == S_STOP) && (clk_cnt == STOP_LAST);
  // The FIFO head is only consumed at frame boundaries: from IDLE or on the last stop cycle.
  assign pop          = (count != '0) && ((state == S_IDLE) || frame_end);

  // NOTE: storage array carries no reset; only pointers and count define valid contents.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  // NOTE: all sequential state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (i_Tx_DV && !o_Tx_Ready) o_Overflow <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_Tx_Serial <= 1'b1;
          if (pop) begin
            shift       <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_q    <= ^mem[rd_ptr] ^ PARITY_ODD;
`endif
            clk_cnt     <= '0;
            state       <= S_START;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
          end else begin
            o_Tx_Active <= 1'b0;
          end
        end

        S_START: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt     <= '0;
            bit_idx     <= '0;
            state       <= S_DATA;
            o_Tx_Serial <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end

        S_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state       <= S_PARITY;
              o_Tx_Serial <= parity_q;
`else
              state       <= S_STOP;
              o_Tx_Serial <= 1'b1;
`endif
            end else begin
              // Shift right so the next data bit always sits at index 1.
              bit_idx     <= bit_idx + BIT_W'(1);
              shift       <= shift >> 1;
              o_Tx_Serial <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt     <= '0;
            state       <= S_STOP;
            o_Tx_Serial <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (clk_cnt == STOP_LAST) begin
            clk_cnt <= '0;
            if (pop) begin
              shift       <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
              parity_q    <= ^mem[rd_ptr] ^ PARITY_ODD;
`endif
              state       <= S_START;
              o_Tx_Serial <= 1'b0;
            end else begin
              state       <= S_IDLE;
              o_Tx_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
            // Registered pulse lands on the final stop cycle itself.
            o_Tx_Done <= (clk_cnt == STOP_PRE);
          end
        end

        default: begin
          state       <= S_IDLE;
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: dut0 is 8N1/even, dut1 has two stop bits and odd parity.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       dv0 = 1'b0, dv1 = 1'b0;
  logic [7:0] byte0 = '0, byte1 = '0;
  logic       ready0, serial0, active0, done0, ovf0;
  logic       ready1, serial1, active1, done1, ovf1;
  logic [2:0] count0, count1;

  int checks = 0;
  int failures = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(1'b0)) dut0 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv0), .i_Tx_Byte(byte0),
    .o_Tx_Ready(ready0), .o_Tx_Serial(serial0), .o_Tx_Active(active0),
    .o_Tx_Done(done0), .o_Fifo_Count(count0), .o_Overflow(ovf0));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(2),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(1'b1)) dut1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv1), .i_Tx_Byte(byte1),
    .o_Tx_Ready(ready1), .o_Tx_Serial(serial1), .o_Tx_Active(active1),
    .o_Tx_Done(done1), .o_Fifo_Count(count1), .o_Overflow(ovf1));

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic write_word(input logic s, input logic [7:0] data);
    if (s) begin dv1 = 1'b1; byte1 = data; end
    else   begin dv0 = 1'b1; byte0 = data; end
    @(negedge clk);
    dv0 = 1'b0;
    dv1 = 1'b0;
  endtask

  // Walks one frame from cycle c0 (cycle 0 = first start-bit cycle) to its end.
  task automatic check_frame(input logic s, input logic [7:0] data, input int stop_bits,
                             input bit odd, input int c0);
    int   len;
    int   bit_no;
    logic exp_s, exp_d, act_s, act_d, act_a;
    len = (1 + DB + P + stop_bits) * CPB;
    for (int c = c0; c < len; c++) begin
      bit_no = c / CPB;
      if (bit_no == 0)                    exp_s = 1'b0;
      else if (bit_no <= DB)              exp_s = data[bit_no-1];
      else if (P == 1 && bit_no == DB+1)  exp_s = ^data ^ odd;
      else                                exp_s = 1'b1;
      exp_d = (c == len - 1);
      act_s = s ? serial1 : serial0;
      act_d = s ? done1   : done0;
      act_a = s ? active1 : active0;
      checks++;
      if (act_s !== exp_s) begin
        failures++;
        $display("FAIL frame_serial dut%0d data=%h cycle=%0d got=%b want=%b", s, data, c, act_s, exp_s);
      end
      checks++;
      if (act_d !== exp_d) begin
        failures++;
        $display("FAIL frame_done dut%0d data=%h cycle=%0d got=%b want=%b", s, data, c, act_d, exp_d);
      end
      checks++;
      if (act_a !== 1'b1) begin
        failures++;
        $display("FAIL frame_active dut%0d data=%h cycle=%0d got=%b want=1", s, data, c, act_a);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (serial0 !== 1'b1) begin failures++; $display("FAIL reset_serial got=%b want=1", serial0); end
    checks++; if (active0 !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", active0); end
    checks++; if (done0   !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done0); end
    checks++; if (ready0  !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready0); end
    checks++; if (count0  !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count0); end
    checks++; if (ovf0    !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", ovf0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    write_word(1'b0, 8'h41);
    checks++; if (serial0 !== 1'b1) begin failures++; $display("FAIL latency_serial got=%b want=1", serial0); end
    checks++; if (active0 !== 1'b0) begin failures++; $display("FAIL latency_active got=%b want=0", active0); end
    checks++; if (count0  !== 3'd1) begin failures++; $display("FAIL latency_count got=%0d want=1", count0); end
    @(negedge clk);
    checks++; if (count0  !== 3'd0) begin failures++; $display("FAIL pop_count got=%0d want=0", count0); end
    check_frame(1'b0, 8'h41, 1, 1'b0, 0);
    checks++; if (active0 !== 1'b0) begin failures++; $display("FAIL single_end_active got=%b want=0", active0); end
    checks++; if (serial0 !== 1'b1) begin failures++; $display("FAIL single_end_serial got=%b want=1", serial0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [4];
    logic [2:0] exp_cnt [4];
    w = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
    // The first word is popped on the edge after it lands, so occupancy lags the writes by one.
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3};
    dv0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte0 = w[i];
      @(negedge clk);
      checks++;
      if (count0 !== exp_cnt[i]) begin
        failures++;
        $display("FAIL burst_fill_count idx=%0d got=%0d want=%0d", i, count0, exp_cnt[i]);
      end
    end
    dv0 = 1'b0;
    check_frame(1'b0, w[0], 1, 1'b0, 2);
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (count0 !== 3'(3 - i)) begin
        failures++;
        $display("FAIL burst_drain_count idx=%0d got=%0d want=%0d", i, count0, 3 - i);
      end
      check_frame(1'b0, w[i], 1, 1'b0, 0);
    end
    checks++; if (active0 !== 1'b0) begin failures++; $display("FAIL burst_end_active got=%b want=0", active0); end
    checks++; if (count0  !== 3'd0) begin failures++; $display("FAIL burst_end_count got=%0d want=0", count0); end
  endtask

  task automatic test_overflow();
    logic [7:0] w [5];
    w = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b want=0", ovf0); end
    write_word(1'b0, 8'h11);
    @(negedge clk);
    dv0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte0 = w[i];
      @(negedge clk);
      checks++;
      if (count0 !== 3'((i < 4) ? i + 1 : 4)) begin
        failures++;
        $display("FAIL ovf_count idx=%0d got=%0d want=%0d", i, count0, (i < 4) ? i + 1 : 4);
      end
      if (i == 3) begin
        checks++;
        if (ready0 !== 1'b0) begin failures++; $display("FAIL ovf_ready_full got=%b want=0", ready0); end
      end
    end
    dv0 = 1'b0;
    checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", ovf0); end
    check_frame(1'b0, 8'h11, 1, 1'b0, 5);
    for (int i = 0; i < 4; i++) check_frame(1'b0, w[i], 1, 1'b0, 0);
    checks++; if (active0 !== 1'b0) begin failures++; $display("FAIL ovf_no_fifth_frame got=%b want=0", active0); end
    checks++; if (count0  !== 3'd0) begin failures++; $display("FAIL ovf_end_count got=%0d want=0", count0); end
    checks++; if (ovf0    !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", ovf0); end
  endtask

  task automatic test_parity();
    write_word(1'b0, 8'h07);
    @(negedge clk);
    check_frame(1'b0, 8'h07, 1, 1'b0, 0);
    checks++; if (active0 !== 1'b0) begin failures++; $display("FAIL parity_even_end got=%b want=0", active0); end
    write_word(1'b1, 8'h07);
    @(negedge clk);
    check_frame(1'b1, 8'h07, 2, 1'b1, 0);
    checks++; if (active1 !== 1'b0) begin failures++; $display("FAIL parity_odd_end got=%b want=0", active1); end
  endtask

  task automatic test_two_stop();
    write_word(1'b1, 8'h00);
    @(negedge clk);
    check_frame(1'b1, 8'h00, 2, 1'b1, 0);
    checks++; if (active1 !== 1'b0) begin failures++; $display("FAIL two_stop_end_active got=%b want=0", active1); end
    checks++; if (serial1 !== 1'b1) begin failures++; $display("FAIL two_stop_end_serial got=%b want=1", serial1); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    write_word(1'b0, 8'hA1);
    @(negedge clk);
    write_word(1'b0, 8'hB2);
    write_word(1'b0, 8'hC3);
    repeat (8) @(negedge clk);
    checks++; if (count0 !== 3'd2) begin failures++; $display("FAIL midrst_queued got=%0d want=2", count0); end
    rst_n = 1'b0;
    #1;
    checks++; if (serial0 !== 1'b1) begin failures++; $display("FAIL midrst_serial got=%b want=1", serial0); end
    checks++; if (active0 !== 1'b0) begin failures++; $display("FAIL midrst_active got=%b want=0", active0); end
    checks++; if (count0  !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d want=0", count0); end
    checks++; if (ready0  !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", ready0); end
    checks++; if (ovf0    !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b want=0", ovf0); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (serial0 !== 1'b1 || active0 !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL midrst_quiet busy_cycles got=%0d want=0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_two_stop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
